irr_priority_isr: RTL and testbench
===================================

IRR_PRIORITY_ISR -- requirements
Module: irr_priority_isr

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port ir, input, 8, raw interrupt request lines IR7..IR0.
REQ-004 SHALL have port ltim, input, 1, 1 = level-triggered, 0 = edge-triggered.
REQ-005 SHALL have port mask, input, 8, interrupt mask (OCW1); 1 = masked.
REQ-006 SHALL have port aeoi, input, 1, auto-EOI mode enable.
REQ-007 SHALL have port auto_rotate, input, 1, rotate-in-AEOI enable.
REQ-008 SHALL have port set_isr, input, 1, one-cycle pulse marking the first INTA.
REQ-009 SHALL have port end_inta, input, 1, one-cycle pulse marking the end of the second INTA.
REQ-010 SHALL have port eoi_valid, input, 1, one-cycle OCW2 EOI command strobe.
REQ-011 SHALL have port eoi_specific, input, 1, 1 = specific EOI, 0 = non-specific EOI.
REQ-012 SHALL have port eoi_id, input, 3, target IR for a specific EOI.
REQ-013 SHALL have port irr, output, 8, interrupt request register.
REQ-014 SHALL have port isr, output, 8, in-service register.
REQ-015 SHALL have port int_req, output, 1, registered interrupt request to the control logic.
REQ-016 SHALL have port ack_id, output, 3, IR number latched at set_isr; feeds the vector low bits.
REQ-017 SHALL have port top_isr_id, output, 3, highest-priority in-service IR; valid when isr != 0.

Function
REQ-018 SHALL register ir into ir_q every cycle.
REQ-019 SHALL, in edge mode, set irr[n] when ir[n] & ~ir_q[n], and clear irr[n] when ir[n] is low.
REQ-020 SHALL, in level mode, set irr[n] to ir[n] each cycle.
REQ-021 SHALL hold a 3-bit lowest-priority pointer lp; priority order is lp+1 (highest) through lp (lowest), wrapping mod 8.
REQ-022 SHALL compute candidates as irr & ~mask and select the highest-priority candidate in rotated order.
REQ-023 SHALL assert int_req one cycle after irr settles, if a candidate exists whose priority is strictly higher than every isr bit (fully nested).
REQ-024 SHALL deassert int_req in the cycle after set_isr, or when its qualifying condition drops.
REQ-025 SHALL, on set_isr with a valid candidate c, set isr[c], clear irr[c], and load ack_id = c in the same edge.
REQ-026 SHALL, on set_isr with no candidate (spurious request), load ack_id = 7 and leave isr and irr unchanged.
REQ-027 SHALL, on end_inta with aeoi = 1, clear isr[ack_id].
REQ-028 SHALL, on end_inta with aeoi = 1 and auto_rotate = 1, also load lp = ack_id.
REQ-029 SHALL, on end_inta with aeoi = 0, leave isr unchanged.
REQ-030 SHALL, on a specific EOI (eoi_valid & eoi_specific), clear isr[eoi_id]; clearing a bit that is already 0 is a no-op.
REQ-031 SHALL, on a non-specific EOI, clear isr[top_isr_id]; if isr == 0 it SHALL have no effect.
REQ-032 SHALL drive top_isr_id combinationally from isr in rotated order; it SHALL read 7 when isr == 0.
REQ-033 SHALL apply set_isr and EOI together when they target different bits; on the same bit in the same cycle, the set SHALL win.
REQ-034 SHALL give the acknowledge clear (REQ-025) precedence over a new edge on the same irr bit in the same cycle; the edge SHALL be lost.
REQ-035 SHALL treat mask changes as effective for candidate selection in the same cycle; masking SHALL NOT alter irr or isr.

Reset
REQ-036 SHALL, on rst high, asynchronously force irr = 0, isr = 0, ir_q = 0, int_req = 0, ack_id = 0, lp = 7 (IR0 highest).
REQ-037 SHALL abandon any acknowledge in progress on reset, with no pending state retained; normal operation SHALL resume on the first clock edge after rst falls.

Verification
REQ-038 Edge mode, mask = 0, ir = 8'h24 rising together -> irr = 8'h24; int_req = 1 one cycle later; set_isr -> isr = 8'h04, irr = 8'h20, ack_id = 2.
REQ-039 With isr = 8'h04, raise ir[5] -> int_req stays 0; then raise ir[0] -> int_req = 1 (IR0 higher than IR2).
REQ-040 aeoi = 1, auto_rotate = 1, acknowledge IR3 then pulse end_inta -> isr = 0, lp = 3; IR4 then has highest priority and IR3 lowest.
REQ-041 isr = 8'h0A, non-specific EOI -> isr = 8'h08; then specific EOI with eoi_id = 3 -> isr = 8'h00; then a non-specific EOI with isr = 0 -> no change.
REQ-042 Raise ir[6] then drop it before set_isr, then pulse set_isr -> ack_id = 7, isr unchanged; assert rst mid-acknowledge -> all outputs match REQ-036 with no clock edge needed.

Source files
------------

// File: rtl/irr_priority_isr.sv
// -----------------------------------------------------------------------------
// irr_priority_isr
//   Interrupt request / in-service register pair with rotating priority
//   resolution, in the style of an 8259-class interrupt controller.
//
//   Ports
//     clk          : single clock, all state changes on the rising edge
//     rst          : asynchronous active-high reset
//     ir[7:0]      : raw interrupt request lines
//     ltim         : 1 = level-triggered, 0 = edge-triggered
//     mask[7:0]    : interrupt mask, 1 = masked (affects selection only)
//     aeoi         : auto-EOI mode, the ISR bit is cleared at end of INTA
//     auto_rotate  : in auto-EOI mode, make the acknowledged IR lowest priority
//     set_isr      : first-INTA pulse, moves the winning request into service
//     end_inta     : end-of-second-INTA pulse
//     eoi_valid    : EOI command strobe
//     eoi_specific : 1 = clear isr[eoi_id], 0 = clear highest in-service bit
//     eoi_id[2:0]  : target IR for a specific EOI
//     irr[7:0]     : interrupt request register
//     isr[7:0]     : in-service register
//     int_req      : registered request towards the control logic
//     ack_id[2:0]  : IR latched at set_isr (7 on a spurious acknowledge)
//     top_isr_id   : highest-priority in-service IR, 7 when nothing in service
// -----------------------------------------------------------------------------
module irr_priority_isr (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic [7:0] mask,
    input  logic       aeoi,
    input  logic       auto_rotate,
    input  logic       set_isr,
    input  logic       end_inta,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_id,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic       int_req,
    output logic [2:0] ack_id,
    output logic [2:0] top_isr_id
);

    // Returns {found, id} of the highest-priority set bit of vec when lp is
    // the lowest-priority position. The scan walks from lowest to highest
    // priority so the last hit is the winner; id reads 7 when nothing is set.
    function automatic logic [3:0] pick_highest(input logic [7:0] vec,
                                                input logic [2:0] lp);
        logic [3:0] res;
        logic [2:0] idx;
        res = {1'b0, 3'd7};
        for (logic [3:0] i = 4'd8; i != 4'd0; i = i - 4'd1) begin
            idx = lp + i[2:0];
            if (vec[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Priority rank of an IR: 0 is the highest (lp + 1), 7 the lowest (lp).
    function automatic logic [2:0] prio_rank(input logic [2:0] id,
                                             input logic [2:0] lp);
        return id - lp - 3'd1;
    endfunction

    logic [7:0] ir_q_r;
    logic [7:0] irr_r;
    logic [7:0] isr_r;
    logic       int_req_r;
    logic [2:0] ack_id_r;
    logic [2:0] lp_r;

    logic [7:0] cand_s;
    logic       cand_valid_s;
    logic [2:0] cand_id_s;
    logic       isr_any_s;
    logic [2:0] top_id_s;
    logic       nested_ok_s;
    logic [7:0] set_bit_s;
    logic [7:0] clr_bit_s;
    logic [7:0] irr_nxt_s;
    logic [7:0] isr_nxt_s;
    logic [2:0] ack_id_nxt_s;
    logic [2:0] lp_nxt_s;

    // Priority resolution and next-state computation for both registers.
    always_comb begin
        cand_s                      = irr_r & ~mask;
        {cand_valid_s, cand_id_s}   = pick_highest(cand_s, lp_r);
        {isr_any_s, top_id_s}       = pick_highest(isr_r, lp_r);

        // Fully nested: the candidate must outrank everything in service.
        if (!cand_valid_s) begin
            nested_ok_s = 1'b0;
        end else if (!isr_any_s) begin
            nested_ok_s = 1'b1;
        end else begin
            nested_ok_s = (prio_rank(cand_id_s, lp_r) < prio_rank(top_id_s, lp_r));
        end

        // A request that is acknowledged this edge moves into service; the
        // IRR clear below also swallows any edge arriving on that bit.
        if (set_isr && cand_valid_s) begin
            set_bit_s    = 8'd1 << cand_id_s;
            ack_id_nxt_s = cand_id_s;
        end else if (set_isr) begin
            set_bit_s    = 8'd0;
            ack_id_nxt_s = 3'd7;
        end else begin
            set_bit_s    = 8'd0;
            ack_id_nxt_s = ack_id_r;
        end

        // Edge mode keeps a bit only while the line stays high; a new bit
        // needs a low-to-high transition seen against ir_q.
        if (ltim) begin
            irr_nxt_s = ir & ~set_bit_s;
        end else begin
            irr_nxt_s = ir & (irr_r | ~ir_q_r) & ~set_bit_s;
        end

        clr_bit_s = 8'd0;
        if (eoi_valid && eoi_specific) begin
            clr_bit_s = clr_bit_s | (8'd1 << eoi_id);
        end else if (eoi_valid && isr_any_s) begin
            clr_bit_s = clr_bit_s | (8'd1 << top_id_s);
        end else begin
            clr_bit_s = clr_bit_s;
        end

        if (end_inta && aeoi) begin
            clr_bit_s = clr_bit_s | (8'd1 << ack_id_r);
        end else begin
            clr_bit_s = clr_bit_s;
        end

        if (end_inta && aeoi && auto_rotate) begin
            lp_nxt_s = ack_id_r;
        end else begin
            lp_nxt_s = lp_r;
        end

        // Set is applied after clear so it wins on a shared bit.
        isr_nxt_s = (isr_r & ~clr_bit_s) | set_bit_s;
    end

    // State registers; reset leaves IR0 highest priority and nothing pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q_r    <= 8'd0;
            irr_r     <= 8'd0;
            isr_r     <= 8'd0;
            int_req_r <= 1'b0;
            ack_id_r  <= 3'd0;
            lp_r      <= 3'd7;
        end else begin
            ir_q_r    <= ir;
            irr_r     <= irr_nxt_s;
            isr_r     <= isr_nxt_s;
            int_req_r <= nested_ok_s && !set_isr;
            ack_id_r  <= ack_id_nxt_s;
            lp_r      <= lp_nxt_s;
        end
    end

    assign irr        = irr_r;
    assign isr        = isr_r;
    assign int_req    = int_req_r;
    assign ack_id     = ack_id_r;
    assign top_isr_id = top_id_s;

endmodule

// File: tb/tb_irr_priority_isr.sv
// -----------------------------------------------------------------------------
// tb_irr_priority_isr
//   Directed bench for irr_priority_isr. A behavioural model of the request /
//   in-service registers is compared against the DUT on every falling edge
//   outside reset; directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_irr_priority_isr;

    logic       clk;
    logic       rst;
    logic [7:0] ir;
    logic       ltim;
    logic [7:0] mask;
    logic       aeoi;
    logic       auto_rotate;
    logic       set_isr;
    logic       end_inta;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_id;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       int_req;
    logic [2:0] ack_id;
    logic [2:0] top_isr_id;

    int vectors    = 0;
    int miscompares = 0;

    irr_priority_isr dut (
        .clk          (clk),
        .rst          (rst),
        .ir           (ir),
        .ltim         (ltim),
        .mask         (mask),
        .aeoi         (aeoi),
        .auto_rotate  (auto_rotate),
        .set_isr      (set_isr),
        .end_inta     (end_inta),
        .eoi_valid    (eoi_valid),
        .eoi_specific (eoi_specific),
        .eoi_id       (eoi_id),
        .irr          (irr),
        .isr          (isr),
        .int_req      (int_req),
        .ack_id       (ack_id),
        .top_isr_id   (top_isr_id)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared comparison helper; every failing comparison prints one line.
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [7:0] m_irr, m_isr, m_irq;
    int         m_lp;
    int         m_ack;
    logic       m_int;

    // First set bit of v walking from lp+1 round to lp; -1 if none.
    function automatic int first_in_order(input logic [7:0] v, input int lp);
        for (int k = 0; k < 8; k++) begin
            if (v[(lp + 1 + k) % 8]) return (lp + 1 + k) % 8;
        end
        return -1;
    endfunction

    // Position of an IR in the priority list (0 = highest).
    function automatic int level_of(input int id, input int lp);
        return (id - lp - 1 + 16) % 8;
    endfunction

    int         mc, mt;
    logic [7:0] mn_irr, mn_set, mn_clr;

    // Model update: everything is derived from the state before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_irr = 8'h00; m_isr = 8'h00; m_irq = 8'h00;
            m_lp  = 7;     m_ack = 0;     m_int = 1'b0;
        end else begin
            mc = first_in_order(m_irr & ~mask, m_lp);
            mt = first_in_order(m_isr, m_lp);
            m_int = !set_isr && (mc >= 0) && ((mt < 0) || (level_of(mc, m_lp) < level_of(mt, m_lp)));
            for (int n = 0; n < 8; n++) begin
                if (ltim) mn_irr[n] = ir[n];
                else      mn_irr[n] = ir[n] && (m_irr[n] || !m_irq[n]);
            end
            mn_clr = 8'h00;
            if (eoi_valid && eoi_specific) mn_clr[eoi_id] = 1'b1;
            if (eoi_valid && !eoi_specific && mt >= 0) mn_clr[mt] = 1'b1;
            if (end_inta && aeoi) mn_clr[m_ack] = 1'b1;
            if (end_inta && aeoi && auto_rotate) m_lp = m_ack;
            mn_set = 8'h00;
            if (set_isr) begin
                if (mc >= 0) begin
                    mn_set[mc] = 1'b1;
                    mn_irr[mc] = 1'b0;
                    m_ack = mc;
                end else begin
                    m_ack = 7;
                end
            end
            m_isr = (m_isr & ~mn_clr) | mn_set;
            m_irr = mn_irr;
            m_irq = ir;
        end
    end

    int model_top;

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            model_top = first_in_order(m_isr, m_lp);
            if (model_top < 0) model_top = 7;
            check("cyc_irr", irr, m_irr);
            check("cyc_isr", isr, m_isr);
            check("cyc_int_req", {7'd0, int_req}, {7'd0, m_int});
            check("cyc_ack_id", {5'd0, ack_id}, m_ack[7:0]);
            check("cyc_top_isr_id", {5'd0, top_isr_id}, model_top[7:0]);
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack();
        set_isr = 1'b1;
        tick();
        set_isr = 1'b0;
    endtask

    task automatic endi();
        end_inta = 1'b1;
        tick();
        end_inta = 1'b0;
    endtask

    task automatic eoi(input logic spec, input logic [2:0] id);
        eoi_valid    = 1'b1;
        eoi_specific = spec;
        eoi_id       = id;
        tick();
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        eoi_id       = 3'd0;
    endtask

    initial begin
        rst = 1'b1; ir = 8'h00; ltim = 1'b0; mask = 8'h00; aeoi = 1'b0;
        auto_rotate = 1'b0; set_isr = 1'b0; end_inta = 1'b0;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = 3'd0;
        #12;
        check("rst_irr", irr, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_int_req", {7'd0, int_req}, 8'h00);
        check("rst_ack_id", {5'd0, ack_id}, 8'h00);
        check("rst_top", {5'd0, top_isr_id}, 8'h07);
        tick();
        rst = 1'b0;
        tick();

        // Two edges together; IR2 wins with IR0 highest.
        ir = 8'h24;
        tick();
        check("edge_irr", irr, 8'h24);
        check("edge_int_early", {7'd0, int_req}, 8'h00);
        tick();
        check("edge_int", {7'd0, int_req}, 8'h01);
        ack();
        check("ack2_isr", isr, 8'h04);
        check("ack2_irr", irr, 8'h20);
        check("ack2_id", {5'd0, ack_id}, 8'h02);
        check("ack2_int_drop", {7'd0, int_req}, 8'h00);
        check("ack2_top", {5'd0, top_isr_id}, 8'h02);

        // Lower-priority IR5 is blocked, higher IR0 gets through.
        tick();
        check("nest_block", {7'd0, int_req}, 8'h00);
        ir = 8'h25;
        tick();
        tick();
        check("nest_pass", {7'd0, int_req}, 8'h01);
        ack();
        check("ack0_isr", isr, 8'h05);
        eoi(1'b0, 3'd0);
        check("ns_eoi_top", isr, 8'h04);
        eoi(1'b1, 3'd2);
        check("sp_eoi2", isr, 8'h00);
        ir = 8'h00;
        tick();
        tick();

        // isr = 0A, then non-specific / specific / empty non-specific EOI.
        ir = 8'h08;
        tick();
        tick();
        ack();
        ir = 8'h0A;
        tick();
        tick();
        ack();
        check("isr_0a", isr, 8'h0A);
        check("ack1_id", {5'd0, ack_id}, 8'h01);
        eoi(1'b0, 3'd0);
        check("ns_eoi_0a", isr, 8'h08);
        eoi(1'b1, 3'd3);
        check("sp_eoi3", isr, 8'h00);
        eoi(1'b0, 3'd0);
        check("ns_eoi_empty", isr, 8'h00);
        ir = 8'h00;
        tick();

        // Set and specific EOI on the same bit: the set wins.
        ir = 8'h01;
        tick();
        tick();
        set_isr = 1'b1; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_id = 3'd0;
        tick();
        set_isr = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0;
        check("set_wins", isr, 8'h01);
        eoi(1'b1, 3'd0);
        check("set_wins_clr", isr, 8'h00);
        ir = 8'h00;
        tick();

        // Masked request: no int_req, spurious acknowledge, irr kept.
        mask = 8'h01;
        ir   = 8'h01;
        tick();
        tick();
        check("mask_no_int", {7'd0, int_req}, 8'h00);
        ack();
        check("mask_spur_id", {5'd0, ack_id}, 8'h07);
        check("mask_isr", isr, 8'h00);
        check("mask_irr", irr, 8'h01);
        mask = 8'h00;
        tick();
        check("unmask_int", {7'd0, int_req}, 8'h01);
        ir = 8'h00;
        tick();
        tick();

        // Level mode follows the lines directly.
        ltim = 1'b1;
        ir   = 8'h80;
        tick();
        check("lvl_set", irr, 8'h80);
        ir = 8'h00;
        tick();
        check("lvl_clr", irr, 8'h00);
        ltim = 1'b0;
        tick();

        // Auto-EOI with rotation: IR3 becomes lowest, IR4 highest.
        aeoi = 1'b1; auto_rotate = 1'b1;
        ir = 8'h08;
        tick();
        tick();
        ack();
        check("aeoi_isr", isr, 8'h08);
        endi();
        check("aeoi_clr", isr, 8'h00);
        ir = 8'h00;
        tick();
        ir = 8'h18;
        tick();
        tick();
        ack();
        check("rot_ack4", {5'd0, ack_id}, 8'h04);
        auto_rotate = 1'b0;
        endi();
        check("aeoi_clr4", isr, 8'h00);
        aeoi = 1'b0;
        ir = 8'h00;
        tick();

        // Request withdrawn before acknowledge -> spurious.
        ir = 8'h40;
        tick();
        ir = 8'h00;
        tick();
        check("withdraw_irr", irr, 8'h00);
        ack();
        check("spur_id", {5'd0, ack_id}, 8'h07);
        check("spur_isr", isr, 8'h00);

        // Reset in the middle of an acknowledge, checked without an edge.
        ir = 8'h02;
        tick();
        tick();
        ack();
        check("pre_rst_isr", isr, 8'h02);
        rst = 1'b1;
        #1;
        check("arst_irr", irr, 8'h00);
        check("arst_isr", isr, 8'h00);
        check("arst_int", {7'd0, int_req}, 8'h00);
        check("arst_ack", {5'd0, ack_id}, 8'h00);
        check("arst_top", {5'd0, top_isr_id}, 8'h07);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_irr", irr, 8'h02);
        tick();
        check("post_rst_int", {7'd0, int_req}, 8'h01);
        ir = 8'h00;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
